// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Decimal digits needed to show the largest unsigned value of bin_w bits.
    function automatic int min_digits(input int bin_w);
        longint unsigned v;
        int n;
        v = (64'd1 << bin_w) - 64'd1;
        n = 0;
        while (v != 64'd0) begin
            v = v / 64'd10;
            n = n + 1;
        end
        if (n == 0) begin
            n = 1;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction step for a single BCD digit: values >= 5 get +3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Correct the digit so the following left shift carries into the next decade.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/binary_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Optional two's-complement input mode is enabled by defining BCD_SIGNED_EN.
module binary_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BIN_W-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      bcd_neg,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int REG_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
        $error("binary_bcd_seq: DIGITS too small for BIN_W");
    end

    state_e             state_r;
    state_e             state_nx_s;
    logic [REG_W-1:0]   sr_r;
    logic [REG_W-1:0]   adj_s;
    logic [REG_W-1:0]   shifted_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [BIN_W-1:0]   load_val_s;
    logic               accept_s;
    logic               last_shift_s;

    assign accept_s     = (state_r == IDLE) && in_valid && in_ready;
    assign last_shift_s = (cnt_r == CNT_W'(1));

`ifdef BCD_SIGNED_EN
    logic sign_r;
    // Negative operands convert their magnitude; -2^(BIN_W-1) maps to 2^(BIN_W-1) unsigned.
    assign load_val_s = in_data[BIN_W-1] ? (~in_data + BIN_W'(1)) : in_data;
`else
    assign load_val_s = in_data;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (sr_r [BIN_W + DIGIT_W*g +: DIGIT_W]),
            .digit_out (adj_s[BIN_W + DIGIT_W*g +: DIGIT_W])
        );
    end
    assign adj_s[BIN_W-1:0] = sr_r[BIN_W-1:0];
    assign shifted_s        = adj_s << 1;

    // Next-state selection.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            sr_r      <= '0;
            cnt_r     <= '0;
            in_ready  <= 1'b0;
            bcd_out   <= '0;
            bcd_neg   <= 1'b0;
            out_valid <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_r    <= 1'b0;
`endif
        end else begin
            state_r  <= state_nx_s;
            in_ready <= (state_nx_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sr_r  <= {{BCD_W{1'b0}}, load_val_s};
                        cnt_r <= CNT_W'(BIN_W);
`ifdef BCD_SIGNED_EN
                        sign_r <= in_data[BIN_W-1];
`endif
                    end else begin
                        sr_r  <= sr_r;
                        cnt_r <= cnt_r;
                    end
                end
                SHIFT: begin
                    sr_r  <= shifted_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    // Publish only the final value so bcd_out never shows partial results.
                    if (last_shift_s) begin
                        bcd_out   <= shifted_s[REG_W-1 -: BCD_W];
                        out_valid <= 1'b1;
`ifdef BCD_SIGNED_EN
                        bcd_neg   <= sign_r && (shifted_s[REG_W-1 -: BCD_W] != '0);
`else
                        bcd_neg   <= 1'b0;
`endif
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_bcd_seq.sv
// Directed bench for binary_bcd_seq: vector table plus back-pressure, back-to-back, reset and width sweep.
module tb_binary_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_out;
    logic        bcd_neg;
    logic        out_valid;
    logic        out_ready;

    logic [19:0] in_data_w;
    logic        in_valid_w;
    logic        in_ready_w;
    logic [27:0] bcd_out_w;
    logic        bcd_neg_w;
    logic        out_valid_w;
    logic        out_ready_w;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [11:0] din;
        logic [15:0] bcd;
        logic        neg;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    binary_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bcd_out(bcd_out), .bcd_neg(bcd_neg),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    binary_bcd_seq #(.BIN_W(20), .DIGITS(7)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_w), .in_valid(in_valid_w),
        .in_ready(in_ready_w), .bcd_out(bcd_out_w), .bcd_neg(bcd_neg_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    endtask

    // Full conversion with out_ready high; lat is the edge index at which out_valid is first presented.
    task automatic do_conv(input logic [11:0] d, output logic [15:0] b, output logic n, output int lat);
        @(negedge clk);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_in_ready();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        lat = lat + 1;
        b = bcd_out;
        n = bcd_neg;
        @(posedge clk);
        @(negedge clk);
        check("out_valid_drop", {63'd0, out_valid}, 64'd0);
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [15:0] b;
        logic [15:0] b2;
        logic        n;
        int          lat;
        int          t1;
        int          t2;
        int          k;
        logic [27:0] exp_w;
        logic        exp_wn;

`ifdef BCD_SIGNED_EN
        vecs[0] = '{12'h800, 16'h2048, 1'b1};
        vecs[1] = '{12'hFFF, 16'h0001, 1'b1};
        vecs[2] = '{12'd0,   16'h0000, 1'b0};
        vecs[3] = '{12'd1234, 16'h1234, 1'b0};
        vecs[4] = '{12'hB2E, 16'h1234, 1'b1};
        vecs[5] = '{12'h7FF, 16'h2047, 1'b0};
        exp_w   = 28'h0000001;
        exp_wn  = 1'b1;
`else
        vecs[0] = '{12'd1234, 16'h1234, 1'b0};
        vecs[1] = '{12'd4095, 16'h4095, 1'b0};
        vecs[2] = '{12'd0,    16'h0000, 1'b0};
        vecs[3] = '{12'd987,  16'h0987, 1'b0};
        vecs[4] = '{12'd1,    16'h0001, 1'b0};
        vecs[5] = '{12'd2048, 16'h2048, 1'b0};
        exp_w   = 28'h1048575;
        exp_wn  = 1'b0;
`endif

        rst_n       = 1'b0;
        in_data     = 12'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data_w   = 20'd0;
        in_valid_w  = 1'b0;
        out_ready_w = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_bcd_out",   {48'd0, bcd_out},   64'd0);
        check("rst_bcd_neg",   {63'd0, bcd_neg},   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_first_clk", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 6; i++) begin
            do_conv(vecs[i].din, b, n, lat);
            check($sformatf("vec%0d_bcd", i), {48'd0, b}, {48'd0, vecs[i].bcd});
            check($sformatf("vec%0d_neg", i), {63'd0, n}, {63'd0, vecs[i].neg});
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd13);
        end

        // Back-pressure: hold out_ready low for 10 cycles after the result appears.
        @(negedge clk);
        in_data   = 12'd987;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        wait_in_ready();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("bp_out_valid_seen", {63'd0, out_valid}, 64'd1);
        in_data  = 12'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("bp_bcd_%0d", i),   {48'd0, bcd_out},   64'h0987);
            check($sformatf("bp_ready_%0d", i), {63'd0, in_ready},  64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_release_ready", {63'd0, in_ready},  64'd1);
        check("bp_retain_bcd",    {48'd0, bcd_out},   64'h0987);
        repeat (3) @(negedge clk);
        check("bp_no_spurious", {63'd0, out_valid}, 64'd0);

        // Back-to-back with in_valid held high; the second operand is accepted only after the first handshake.
        in_data   = 12'd100;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_in_ready();
        @(posedge clk);
        @(negedge clk);
        in_data = 12'd200;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        t1 = cyc;
        b  = bcd_out;
        k = 0;
        while (out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        t2 = cyc;
        b2 = bcd_out;
        in_valid = 1'b0;
        check("b2b_first",   {48'd0, b},  64'h0100);
        check("b2b_second",  {48'd0, b2}, 64'h0200);
        check("b2b_spacing", 64'(t2 - t1), 64'd14);
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a conversion.
        in_data  = 12'd555;
        in_valid = 1'b1;
        wait_in_ready();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_bcd",   {48'd0, bcd_out},   64'd0);
        check("mid_rst_ready", {63'd0, in_ready},  64'd0);
        check("mid_rst_neg",   {63'd0, bcd_neg},   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(12'd42, b, n, lat);
        check("post_rst_bcd", {48'd0, b}, 64'h0042);
        check("post_rst_lat", 64'(lat), 64'd13);

        // Wider instance: BIN_W=20, DIGITS=7.
        @(negedge clk);
        in_data_w  = 20'd1048575;
        in_valid_w = 1'b1;
        k = 0;
        while (!in_ready_w && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("w_in_ready", {63'd0, in_ready_w}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_w = 1'b0;
        lat = 0;
        while (!out_valid_w && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("w_lat", 64'(lat + 1), 64'd21);
        check("w_bcd", {36'd0, bcd_out_w}, {36'd0, exp_w});
        check("w_neg", {63'd0, bcd_neg_w}, {63'd0, exp_wn});
        @(negedge clk);
        check("w_valid_drop", {63'd0, out_valid_w}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
